// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT: loads N samples in bit-reversed order,
// runs LOG2N stages on one shared butterfly, then streams bins out in natural order.
module fft_radix2_iter #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned LOG2N = 4,
    parameter int unsigned SCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned N  = 1 << LOG2N;
    localparam int unsigned AW = LOG2N;
    localparam int unsigned JW = LOG2N - 1;
    localparam int unsigned SW = $clog2(LOG2N);
    localparam int unsigned PW = 2 * H + 1;
    // One guard bit beyond the minimum so |W*B| up to sqrt(2) cannot wrap.
    localparam int unsigned XW = H + 2;
    localparam real         PI = 3.14159265358979323846;
    localparam longint      MAXQ = (longint'(1) << (H - 1)) - 1;
    localparam logic signed [XW-1:0] MAXV = XW'(MAXQ);
    localparam logic signed [XW-1:0] MINV = XW'(-MAXQ - 1);
    localparam logic signed [PW-1:0] RND  = PW'(longint'(1) << (H - 2));

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

    state_t          state;
    logic [AW-1:0]   k;
    logic [AW-1:0]   m;
    logic [JW-1:0]   j;
    logic [SW-1:0]   s;
    logic [WIDTH-1:0] mem    [N];
    logic [WIDTH-1:0] tw_rom [N/2];

    function automatic real taylor(input real x, input bit want_sin);
        real term;
        real acc;
        term = want_sin ? x : 1.0;
        acc  = term;
        for (int i = 1; i < 24; i++) begin
            if (want_sin) term = -term * x * x / real'((2 * i) * (2 * i + 1));
            else          term = -term * x * x / real'((2 * i - 1) * (2 * i));
            acc = acc + term;
        end
        return acc;
    endfunction

    // Round to nearest Q1.(H-1); +1.0 clamps to the largest positive code.
    function automatic logic [H-1:0] quant(input real v);
        real    sc;
        longint r;
        sc = v * real'(longint'(1) << (H - 1));
        r  = (sc >= 0.0) ? longint'($rtoi(sc + 0.5)) : -longint'($rtoi(0.5 - sc));
        if (r > MAXQ)      r = MAXQ;
        if (r < -MAXQ - 1) r = -MAXQ - 1;
        return H'(r);
    endfunction

    for (genvar t = 0; t < N / 2; t++) begin : g_tw
        localparam real ANG = 2.0 * PI * real'(t) / real'(N);
        localparam logic [WIDTH-1:0] TW = {quant(taylor(ANG, 1'b0)), quant(-taylor(ANG, 1'b1))};
        assign tw_rom[t] = TW;
    end

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    // Optional halving with round-half-up, then saturate; MSB of the result flags saturation.
    function automatic logic [H:0] post(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] t;
        logic                 sat;
        t = v;
        if (SCALE != 0) begin
            t = v + XW'(1);
            t = t >>> 1;
        end
        sat = 1'b0;
        if (t > MAXV) begin
            t   = MAXV;
            sat = 1'b1;
        end else if (t < MINV) begin
            t   = MINV;
            sat = 1'b1;
        end
        return {sat, H'(t)};
    endfunction

    logic [AW-1:0] jx, span_mask, addr_a, addr_b, rd_addr;
    logic [JW-1:0] tw_idx;
    logic          load_hs;

    always_comb begin
        jx        = AW'(j);
        span_mask = AW'((1 << s) - 1);
        addr_a    = ((jx >> s) << (32'(s) + 1)) | (jx & span_mask);
        addr_b    = addr_a | AW'(1 << s);
        tw_idx    = JW'((jx & span_mask) << (LOG2N - 1 - 32'(s)));
        rd_addr   = addr_a;
        if (state == UNLOAD) rd_addr = out_valid ? m + AW'(1) : m;
        load_hs   = in_ready && in_valid;
    end

    logic [WIDTH-1:0]      word_a, word_b, tw;
    logic signed [H-1:0]   ar, ai, br, bi, wr, wi;
    logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir, pr, pi;
    logic signed [XW-1:0]  wbr, wbi, ax_r, ax_i;
    logic signed [H-1:0]   top_r, top_i, bot_r, bot_i;
    logic                  sat_tr, sat_ti, sat_br, sat_bi, bf_sat;

    // Shared butterfly: full-precision W*B, rounded back to Q1, then add/sub.
    always_comb begin
        word_a = mem[rd_addr];
        word_b = mem[addr_b];
        tw     = tw_rom[tw_idx];
        ar     = word_a[WIDTH-1:H];
        ai     = word_a[H-1:0];
        br     = word_b[WIDTH-1:H];
        bi     = word_b[H-1:0];
        wr     = tw[WIDTH-1:H];
        wi     = tw[H-1:0];
        p_rr   = PW'(br) * PW'(wr);
        p_ii   = PW'(bi) * PW'(wi);
        p_ri   = PW'(br) * PW'(wi);
        p_ir   = PW'(bi) * PW'(wr);
        pr     = p_rr - p_ii + RND;
        pi     = p_ri + p_ir + RND;
        wbr    = XW'(pr >>> (H - 1));
        wbi    = XW'(pi >>> (H - 1));
        ax_r   = XW'(ar);
        ax_i   = XW'(ai);
        {sat_tr, top_r} = post(ax_r + wbr);
        {sat_ti, top_i} = post(ax_i + wbi);
        {sat_br, bot_r} = post(ax_r - wbr);
        {sat_bi, bot_i} = post(ax_i - wbi);
        bf_sat = sat_tr | sat_ti | sat_br | sat_bi;
    end

    // Sample store: loader writes bit-reversed, butterfly writes both legs in place.
    always_ff @(posedge clock) begin
        if (load_hs) begin
            mem[bitrev(k)] <= in_data;
        end else if (state == COMPUTE) begin
            mem[addr_a] <= {top_r, top_i};
            mem[addr_b] <= {bot_r, bot_i};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            k         <= '0;
            m         <= '0;
            j         <= '0;
            s         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        ovf      <= 1'b0;
                        k        <= '0;
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        k <= k + AW'(1);
                        if (k == AW'(N - 1)) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            s        <= '0;
                            j        <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (bf_sat) ovf <= 1'b1;
                    j <= j + JW'(1);
                    if (j == JW'(N / 2 - 1)) begin
                        if (s == SW'(LOG2N - 1)) begin
                            state <= UNLOAD;
                            m     <= '0;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                UNLOAD: begin
                    // First UNLOAD cycle fetches bin 0 once the last butterfly has landed.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= word_a;
                    end else if (out_ready) begin
                        if (m == AW'(N - 1)) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            m        <= m + AW'(1);
                            out_data <= word_a;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
